// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Sequences trap entry and MRET return at the write-back boundary of the RV32
// pipeline. In IDLE it arbitrates between an enabled machine interrupt, the
// synchronous exception of the WB instruction and MRET, then walks a short
// TRAP -> REDIRECT sequence that updates the trap CSRs, holds and flushes the
// pipeline and redirects IF.
//
// Ports
//   clk, rst_b                 core clock, asynchronous active-low reset
//   wb_valid / wb_pc           WB instruction valid and its PC
//   wb_exc_pending/_code/_tval synchronous exception carried by WB
//   wb_mret                    WB instruction is MRET
//   external/software/timer_interrupt  asynchronous interrupt levels
//   csr_mstatus_mie, csr_mie   global and per-source ({MEIE,MTIE,MSIE}) enables
//   csr_mtvec, csr_mepc        trap vector (mode in [1:0]) and MRET target
//   wb_kill, mret_csr_update   acceptance-cycle strobes (combinational)
//   wb_hold, pipe_flush        pipeline hold / flush while sequencing
//   trap_csr_write, trap_*     one-cycle CSR trap update and its data
//   redirect_valid/_pc         PC redirect to IF
// -----------------------------------------------------------------------------
module trap_ctrl #(
   parameter int XLEN        = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            wb_valid,
   input  logic [XLEN-1:0] wb_pc,
   input  logic            wb_exc_pending,
   input  logic [3:0]      wb_exc_code,
   input  logic [XLEN-1:0] wb_exc_tval,
   input  logic            wb_mret,
   input  logic            external_interrupt,
   input  logic            software_interrupt,
   input  logic            timer_interrupt,
   input  logic            csr_mstatus_mie,
   input  logic [2:0]      csr_mie,
   input  logic [XLEN-1:0] csr_mtvec,
   input  logic [XLEN-1:0] csr_mepc,
   output logic            wb_kill,
   output logic            wb_hold,
   output logic            pipe_flush,
   output logic            trap_csr_write,
   output logic [XLEN-1:0] trap_mepc,
   output logic [XLEN-1:0] trap_mcause,
   output logic [XLEN-1:0] trap_mtval,
   output logic            mret_csr_update,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TRAP     = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   localparam logic [3:0] CAUSE_EXT = 4'd11;
   localparam logic [3:0] CAUSE_SW  = 4'd3;
   localparam logic [3:0] CAUSE_TMR = 4'd7;

   // Synchronizer chain; each stage holds {external, timer, software} so the
   // bit order lines up with csr_mie = {MEIE, MTIE, MSIE}.
   logic [SYNC_STAGES-1:0][2:0] sync_r;
   logic [2:0]      irq_raw_s;
   logic [2:0]      irq_pend_s;
   logic            int_take_s;
   logic [3:0]      int_cause_s;
   logic            idle_valid_s;
   logic            accept_int_s;
   logic            accept_exc_s;
   logic            accept_mret_s;

   state_t          state_r;
   logic [XLEN-1:0] target_r;
   logic            wb_hold_r;
   logic            pipe_flush_r;
   logic            trap_csr_write_r;
   logic [XLEN-1:0] trap_mepc_r;
   logic [XLEN-1:0] trap_mcause_r;
   logic [XLEN-1:0] trap_mtval_r;
   logic            redirect_valid_r;
   logic [XLEN-1:0] redirect_pc_r;

   // Trap vector: direct base, plus 4*cause for interrupts in vectored mode.
   // Modes 2'b10 and 2'b11 fall back to direct.
   function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                   input logic            is_int,
                                                   input logic [3:0]      cause);
      logic [XLEN-1:0] base;
      base = {mtvec[XLEN-1:2], 2'b00};
      if (is_int && (mtvec[1:0] == 2'b01)) begin
         trap_target = base + {{(XLEN-6){1'b0}}, cause, 2'b00};
      end else begin
         trap_target = base;
      end
   endfunction

   assign irq_raw_s = {external_interrupt, timer_interrupt, software_interrupt};

   // Level-sensitive multi-flop synchronizer for the three interrupt inputs
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         sync_r <= {(3*SYNC_STAGES){1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], irq_raw_s};
      end
   end

   // Interrupt qualification, source priority and acceptance decode
   always_comb begin
      irq_pend_s   = sync_r[SYNC_STAGES-1] & csr_mie;
      int_take_s   = csr_mstatus_mie & (|irq_pend_s);
      int_cause_s  = 4'd0;
      if (irq_pend_s[2]) begin
         int_cause_s = CAUSE_EXT;
      end else if (irq_pend_s[0]) begin
         int_cause_s = CAUSE_SW;
      end else if (irq_pend_s[1]) begin
         int_cause_s = CAUSE_TMR;
      end else begin
         int_cause_s = 4'd0;
      end
      idle_valid_s  = (state_r == ST_IDLE) & wb_valid;
      accept_int_s  = idle_valid_s & int_take_s;
      // An exception on an MRET wins over the MRET itself.
      accept_exc_s  = idle_valid_s & ~int_take_s & wb_exc_pending;
      accept_mret_s = idle_valid_s & ~int_take_s & ~wb_exc_pending & wb_mret;
   end

   // Acceptance strobes must act in the same cycle; reset forces them low.
   assign wb_kill         = rst_b & (accept_int_s | accept_exc_s);
   assign mret_csr_update = rst_b & accept_mret_s;

   // Trap / return sequencer with registered CSR, hold, flush and redirect outputs
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_r          <= ST_IDLE;
         target_r         <= {XLEN{1'b0}};
         wb_hold_r        <= 1'b0;
         pipe_flush_r     <= 1'b0;
         trap_csr_write_r <= 1'b0;
         trap_mepc_r      <= {XLEN{1'b0}};
         trap_mcause_r    <= {XLEN{1'b0}};
         trap_mtval_r     <= {XLEN{1'b0}};
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= {XLEN{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_int_s || accept_exc_s) begin
                  state_r          <= ST_TRAP;
                  wb_hold_r        <= 1'b1;
                  pipe_flush_r     <= 1'b1;
                  trap_csr_write_r <= 1'b1;
                  trap_mepc_r      <= wb_pc;
                  if (accept_int_s) begin
                     trap_mcause_r <= {1'b1, {(XLEN-5){1'b0}}, int_cause_s};
                     trap_mtval_r  <= {XLEN{1'b0}};
                  end else begin
                     trap_mcause_r <= {1'b0, {(XLEN-5){1'b0}}, wb_exc_code};
                     trap_mtval_r  <= wb_exc_tval;
                  end
                  target_r         <= trap_target(csr_mtvec, accept_int_s, int_cause_s);
                  redirect_valid_r <= 1'b0;
                  redirect_pc_r    <= {XLEN{1'b0}};
               end else if (accept_mret_s) begin
                  state_r          <= ST_REDIRECT;
                  wb_hold_r        <= 1'b1;
                  pipe_flush_r     <= 1'b1;
                  trap_csr_write_r <= 1'b0;
                  redirect_valid_r <= 1'b1;
                  redirect_pc_r    <= csr_mepc;
               end else begin
                  state_r          <= ST_IDLE;
                  wb_hold_r        <= 1'b0;
                  pipe_flush_r     <= 1'b0;
                  trap_csr_write_r <= 1'b0;
                  redirect_valid_r <= 1'b0;
                  redirect_pc_r    <= {XLEN{1'b0}};
               end
            end
            ST_TRAP: begin
               state_r          <= ST_REDIRECT;
               wb_hold_r        <= 1'b1;
               pipe_flush_r     <= 1'b1;
               trap_csr_write_r <= 1'b0;
               redirect_valid_r <= 1'b1;
               redirect_pc_r    <= target_r;
            end
            ST_REDIRECT: begin
               state_r          <= ST_IDLE;
               wb_hold_r        <= 1'b0;
               pipe_flush_r     <= 1'b0;
               trap_csr_write_r <= 1'b0;
               redirect_valid_r <= 1'b0;
               redirect_pc_r    <= {XLEN{1'b0}};
            end
            default: begin
               state_r          <= ST_IDLE;
               wb_hold_r        <= 1'b0;
               pipe_flush_r     <= 1'b0;
               trap_csr_write_r <= 1'b0;
               redirect_valid_r <= 1'b0;
               redirect_pc_r    <= {XLEN{1'b0}};
            end
         endcase
      end
   end

   assign wb_hold        = wb_hold_r;
   assign pipe_flush     = pipe_flush_r;
   assign trap_csr_write = trap_csr_write_r;
   assign trap_mepc      = trap_mepc_r;
   assign trap_mcause    = trap_mcause_r;
   assign trap_mtval     = trap_mtval_r;
   assign redirect_valid = redirect_valid_r;
   assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_trap_ctrl.sv
`timescale 1ns/1ps
module tb_trap_ctrl;
   localparam int XLEN = 32;
   localparam int SS   = 2;
   localparam int MAXC = 1024;

   logic            clk = 1'b0;
   logic            rst_b;
   logic            wb_valid, wb_exc_pending, wb_mret;
   logic [31:0]     wb_pc, wb_exc_tval;
   logic [3:0]      wb_exc_code;
   logic            external_interrupt, software_interrupt, timer_interrupt;
   logic            csr_mstatus_mie;
   logic [2:0]      csr_mie;
   logic [31:0]     csr_mtvec, csr_mepc;
   logic            wb_kill, wb_hold, pipe_flush, trap_csr_write;
   logic [31:0]     trap_mepc, trap_mcause, trap_mtval;
   logic            mret_csr_update, redirect_valid;
   logic [31:0]     redirect_pc;

   trap_ctrl #(.XLEN(XLEN), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_b(rst_b),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc_pending(wb_exc_pending),
      .wb_exc_code(wb_exc_code), .wb_exc_tval(wb_exc_tval), .wb_mret(wb_mret),
      .external_interrupt(external_interrupt), .software_interrupt(software_interrupt),
      .timer_interrupt(timer_interrupt), .csr_mstatus_mie(csr_mstatus_mie),
      .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
      .wb_kill(wb_kill), .wb_hold(wb_hold), .pipe_flush(pipe_flush),
      .trap_csr_write(trap_csr_write), .trap_mepc(trap_mepc),
      .trap_mcause(trap_mcause), .trap_mtval(trap_mtval),
      .mret_csr_update(mret_csr_update), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: per-cycle expectation schedule plus raw interrupt history.
   bit        e_tcw[MAXC], e_hold[MAXC], e_flush[MAXC], e_rv[MAXC];
   bit [31:0] e_rpc[MAXC], e_mepc[MAXC], e_mcause[MAXC], e_mtval[MAXC];
   bit [2:0]  hist[MAXC];   // {ext, tmr, sw} level seen in each cycle
   int        busy_until = -1;

   task automatic sched_trap(input int k, input bit [31:0] pc, input bit [31:0] cause,
                             input bit [31:0] tval, input bit [31:0] tgt);
      e_tcw[k+1] = 1'b1; e_hold[k+1] = 1'b1; e_flush[k+1] = 1'b1;
      e_mepc[k+1] = pc; e_mcause[k+1] = cause; e_mtval[k+1] = tval;
      e_rv[k+2] = 1'b1; e_hold[k+2] = 1'b1; e_flush[k+2] = 1'b1; e_rpc[k+2] = tgt;
      busy_until = k + 2;
   endtask

   initial begin : model_cmp
      int k;
      bit [2:0] syn, pend;
      bit [3:0] cause;
      bit e_kill, e_mret;
      bit [31:0] base;
      forever begin
         @(negedge clk);
         #2;
         k = cyc;
         if (k < MAXC - 3) begin
            if (!rst_b) begin
               for (int i = 0; i < MAXC; i++) begin
                  e_tcw[i] = 0; e_hold[i] = 0; e_flush[i] = 0; e_rv[i] = 0;
                  e_rpc[i] = 0; e_mepc[i] = 0; e_mcause[i] = 0; e_mtval[i] = 0;
                  hist[i] = 0;
               end
               busy_until = k;
               chk("rst_outs", {wb_kill, wb_hold, pipe_flush, trap_csr_write,
                                mret_csr_update, redirect_valid}, 32'd0);
               chk("rst_data", trap_mepc | trap_mcause | trap_mtval | redirect_pc, 32'd0);
            end else begin
               hist[k] = {external_interrupt, timer_interrupt, software_interrupt};
               e_kill = 0; e_mret = 0;
               base = {csr_mtvec[31:2], 2'b00};
               if (k > busy_until && wb_valid) begin
                  syn  = (k >= SS) ? hist[k-SS] : 3'b000;
                  pend = syn & csr_mie;
                  if (csr_mstatus_mie && pend != 3'b000) begin
                     cause  = pend[2] ? 4'd11 : (pend[0] ? 4'd3 : 4'd7);
                     e_kill = 1;
                     sched_trap(k, wb_pc, 32'h8000_0000 + cause, 32'd0,
                                (csr_mtvec[1:0] == 2'b01) ? base + 32'd4 * cause : base);
                  end else if (wb_exc_pending) begin
                     e_kill = 1;
                     sched_trap(k, wb_pc, {28'd0, wb_exc_code}, wb_exc_tval, base);
                  end else if (wb_mret) begin
                     e_mret = 1;
                     e_rv[k+1] = 1; e_hold[k+1] = 1; e_flush[k+1] = 1; e_rpc[k+1] = csr_mepc;
                     busy_until = k + 1;
                  end
               end
               chk("m_wb_kill", wb_kill, e_kill);
               chk("m_mret_upd", mret_csr_update, e_mret);
               chk("m_tcw", trap_csr_write, e_tcw[k]);
               chk("m_hold", wb_hold, e_hold[k]);
               chk("m_flush", pipe_flush, e_flush[k]);
               chk("m_rv", redirect_valid, e_rv[k]);
               if (e_rv[k]) chk("m_rpc", redirect_pc, e_rpc[k]);
               if (e_tcw[k]) begin
                  chk("m_mepc", trap_mepc, e_mepc[k]);
                  chk("m_mcause", trap_mcause, e_mcause[k]);
                  chk("m_mtval", trap_mtval, e_mtval[k]);
               end
            end
         end
      end
   end

   task automatic set_wb(input bit v, input bit [31:0] pc, input bit exc,
                         input bit [3:0] code, input bit [31:0] tval, input bit mret);
      wb_valid = v; wb_pc = pc; wb_exc_pending = exc;
      wb_exc_code = code; wb_exc_tval = tval; wb_mret = mret;
   endtask

   // Directed stimulus with hand-computed expectations
   initial begin : stim
      bit seen;
      rst_b = 1'b0;
      set_wb(0, 32'd0, 0, 4'd0, 32'd0, 0);
      external_interrupt = 0; software_interrupt = 0; timer_interrupt = 0;
      csr_mstatus_mie = 0; csr_mie = 3'b000;
      csr_mtvec = 32'h8000_0000; csr_mepc = 32'd0;
      repeat (2) @(negedge clk);
      #3;
      chk("reset_tcw", trap_csr_write, 32'd0);
      chk("reset_rv", redirect_valid, 32'd0);
      @(negedge clk); rst_b = 1'b1;
      repeat (2) @(negedge clk);

      // Exception in IDLE
      @(negedge clk); set_wb(1, 32'h8000_0100, 1, 4'd2, 32'h0000_0013, 0);
      #3; chk("t1_kill", wb_kill, 32'd1);
      @(negedge clk); set_wb(0, 32'd0, 0, 4'd0, 32'd0, 0);
      #3; chk("t1_tcw", trap_csr_write, 32'd1);
      chk("t1_mepc", trap_mepc, 32'h8000_0100);
      chk("t1_mcause", trap_mcause, 32'h0000_0002);
      chk("t1_mtval", trap_mtval, 32'h0000_0013);
      @(negedge clk);
      #3; chk("t1_rv", redirect_valid, 32'd1);
      chk("t1_rpc", redirect_pc, 32'h8000_0000);
      repeat (2) @(negedge clk);

      // Vectored external interrupt
      csr_mtvec = 32'h8000_0001; csr_mie = 3'b111; csr_mstatus_mie = 1;
      @(negedge clk); external_interrupt = 1;
      repeat (SS) @(negedge clk);
      set_wb(1, 32'h8000_0300, 0, 4'd0, 32'd0, 0);
      #3; chk("t2_kill", wb_kill, 32'd1);
      @(negedge clk); external_interrupt = 0; set_wb(0, 32'd0, 0, 4'd0, 32'd0, 0);
      #3; chk("t2_mcause", trap_mcause, 32'h8000_000B);
      chk("t2_mepc", trap_mepc, 32'h8000_0300);
      @(negedge clk);
      #3; chk("t2_rpc", redirect_pc, 32'h8000_002C);
      repeat (3) @(negedge clk);

      // Timer interrupt and exception on the same instruction
      @(negedge clk); timer_interrupt = 1;
      repeat (SS) @(negedge clk);
      set_wb(1, 32'h8000_0400, 1, 4'd5, 32'h0000_1234, 0);
      #3; chk("t3_kill", wb_kill, 32'd1);
      @(negedge clk); timer_interrupt = 0; set_wb(0, 32'd0, 0, 4'd0, 32'd0, 0);
      #3; chk("t3_mcause", trap_mcause, 32'h8000_0007);
      chk("t3_mtval", trap_mtval, 32'd0);
      @(negedge clk);
      #3; chk("t3_rpc", redirect_pc, 32'h8000_001C);
      @(negedge clk);
      #3; chk("t3_no_second", trap_csr_write, 32'd0);
      repeat (3) @(negedge clk);

      // MRET
      csr_mepc = 32'h8000_0200;
      @(negedge clk); set_wb(1, 32'h8000_0500, 0, 4'd0, 32'd0, 1);
      #3; chk("t4_mret", mret_csr_update, 32'd1);
      chk("t4_kill", wb_kill, 32'd0);
      @(negedge clk); set_wb(0, 32'd0, 0, 4'd0, 32'd0, 0);
      #3; chk("t4_rpc", redirect_pc, 32'h8000_0200);
      chk("t4_rv", redirect_valid, 32'd1);
      chk("t4_tcw", trap_csr_write, 32'd0);
      repeat (2) @(negedge clk);

      // Exception together with MRET behaves as an exception
      @(negedge clk); set_wb(1, 32'h8000_0600, 1, 4'd3, 32'h0000_0055, 1);
      #3; chk("t4b_mret", mret_csr_update, 32'd0);
      @(negedge clk); set_wb(0, 32'd0, 0, 4'd0, 32'd0, 0);
      #3; chk("t4b_mcause", trap_mcause, 32'h0000_0003);
      @(negedge clk);
      #3; chk("t4b_rpc", redirect_pc, 32'h8000_0000);
      repeat (2) @(negedge clk);

      // Globally masked software interrupt
      csr_mstatus_mie = 0;
      @(negedge clk); software_interrupt = 1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); set_wb(1, 32'h8000_1000 + 32'(4 * i), 0, 4'd0, 32'd0, 0);
         #3; seen = seen | wb_kill | wb_hold | pipe_flush;
      end
      @(negedge clk); set_wb(0, 32'd0, 0, 4'd0, 32'd0, 0); software_interrupt = 0;
      chk("t5_masked", {31'd0, seen}, 32'd0);
      repeat (SS + 2) @(negedge clk);
      csr_mstatus_mie = 1; csr_mtvec = 32'h8000_0000;

      // Reset during TRAP
      @(negedge clk); set_wb(1, 32'h8000_0700, 1, 4'd7, 32'h0000_DEAD, 0);
      @(negedge clk); set_wb(0, 32'd0, 0, 4'd0, 32'd0, 0); rst_b = 0;
      #3; chk("t6_rst_outs", {wb_hold, pipe_flush, trap_csr_write, redirect_valid}, 32'd0);
      @(negedge clk); rst_b = 1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #3; seen = seen | redirect_valid | trap_csr_write;
      end
      chk("t6_no_redirect", {31'd0, seen}, 32'd0);
      @(negedge clk); set_wb(1, 32'h8000_0800, 1, 4'd4, 32'h0000_BEEF, 0);
      #3; chk("t6_kill", wb_kill, 32'd1);
      @(negedge clk); set_wb(0, 32'd0, 0, 4'd0, 32'd0, 0);
      #3; chk("t6_mcause", trap_mcause, 32'h0000_0004);
      chk("t6_mepc", trap_mepc, 32'h8000_0800);
      @(negedge clk);
      #3; chk("t6_rpc", redirect_pc, 32'h8000_0000);
      repeat (3) @(negedge clk);
      #4;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
